// File: rtl/divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// out = {remainder, quotient}. A division by zero yields quotient = all ones
// and remainder = dividend, with div_by_zero raised alongside done.
// Optional feature macro: DIVIDER_ZERO_FASTPATH_EN. When defined, a zero
// divisor skips the RUN phase and completes two cycles after acceptance.
//
// Handshake: start is a one-cycle request taken only in IDLE when done is
// low. busy is high from the cycle after acceptance until the result cycle.
// done pulses for one cycle when out changes. out holds between dones.
// A start that arrives while busy or during the done cycle is dropped.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   output logic [2*WIDTH-1:0] out,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [1:0]         fsm_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
`ifdef DIVIDER_ZERO_FASTPATH_EN
   logic             fast_wait;
`endif

   // Trial subtraction one bit wider than the operands; the MSB is the borrow.
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvsr};
   end

   assign busy      = (state != IDLE);
   assign fsm_state = state;

   // Control FSM and shift/subtract datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rem         <= '0;
         quo         <= '0;
         dvsr        <= '0;
         cnt         <= '0;
         out         <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef DIVIDER_ZERO_FASTPATH_EN
         fast_wait   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !done) begin
                  quo         <= in1;
                  dvsr        <= in2;
                  rem         <= '0;
                  cnt         <= CW'(WIDTH);
                  div_by_zero <= (in2 == '0);
                  state       <= RUN;
`ifdef DIVIDER_ZERO_FASTPATH_EN
                  // Preload the restoring result directly; the extra DONE
                  // cycle keeps completion two cycles after acceptance.
                  if (in2 == '0) begin
                     rem       <= in1;
                     quo       <= '1;
                     cnt       <= '0;
                     fast_wait <= 1'b1;
                     state     <= DONE;
                  end
`endif
               end
            end
            RUN: begin
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
`ifdef DIVIDER_ZERO_FASTPATH_EN
               if (fast_wait) begin
                  fast_wait <= 1'b0;
               end else begin
                  out   <= {rem, quo};
                  done  <= 1'b1;
                  state <= IDLE;
               end
`else
               out   <= {rem, quo};
               done  <= 1'b1;
               state <= IDLE;
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
